// File: rtl/spi_xfer_arbiter.sv
// Shares one byte-level SPI master between two requesters. Owners get exclusive,
// lockable bursts; stalled bytes and abandoned locks are recovered by timeouts.
module spi_xfer_arbiter #(
    parameter int TIMEOUT_CYCLES = 512,
    parameter int HOLD_MAX       = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req0_valid,
    input  logic [7:0] i_req0_byte,
    input  logic       i_req0_last,
    output logic       o_req0_ready,
    input  logic       i_req1_valid,
    input  logic [7:0] i_req1_byte,
    input  logic       i_req1_last,
    output logic       o_req1_ready,
    output logic       o_rsp0_valid,
    output logic [7:0] o_rsp0_byte,
    output logic       o_rsp0_err,
    output logic       o_rsp1_valid,
    output logic [7:0] o_rsp1_byte,
    output logic       o_rsp1_err,
    output logic [7:0] o_m_tx_byte,
    output logic       o_m_tx_start,
    input  logic       i_m_tx_done,
    input  logic [7:0] i_m_rx_byte,
    output logic       o_busy,
    output logic       o_owner
);

    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_MAX) + 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t            r_state;
    logic              r_rr_ptr;
    logic              r_owner;
    logic              r_last;
    logic              r_busy;
    logic              r_tx_start;
    logic [7:0]        r_tx_byte;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic              r_rsp0_valid;
    logic [7:0]        r_rsp0_byte;
    logic              r_rsp0_err;
    logic              r_rsp1_valid;
    logic [7:0]        r_rsp1_byte;
    logic              r_rsp1_err;

    logic              w_idle;
    logic              w_hold;
    logic              w_grant;
    logic              w_rdy0;
    logic              w_rdy1;
    logic              w_acc;
    logic              w_acc_port;
    logic              w_acc_last;
    logic [7:0]        w_acc_byte;
    logic [TMO_W-1:0]  w_tmo_next;
    logic              w_tmo_expire;
    logic              w_fin;
    logic              w_fin_err;
    logic [7:0]        w_fin_byte;

    function automatic logic [TMO_W-1:0] f_tmo_inc(input logic [TMO_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + TMO_W'(1);
    endfunction

    function automatic logic [HOLD_W-1:0] f_hold_inc(input logic [HOLD_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + HOLD_W'(1);
    endfunction

    assign w_idle = (r_state == S_IDLE);
    assign w_hold = (r_state == S_HOLD);

    // With both ports valid the round-robin pointer decides; otherwise the lone requester wins.
    assign w_grant = (i_req0_valid && i_req1_valid) ? r_rr_ptr : i_req1_valid;

    assign w_rdy0 = rst_n && ((w_idle && i_req0_valid && !w_grant) || (w_hold && !r_owner));
    assign w_rdy1 = rst_n && ((w_idle && i_req1_valid &&  w_grant) || (w_hold &&  r_owner));

    assign w_acc_port = w_rdy1 && i_req1_valid;
    assign w_acc      = (w_rdy0 && i_req0_valid) || w_acc_port;
    assign w_acc_byte = w_acc_port ? i_req1_byte : i_req0_byte;
    assign w_acc_last = w_acc_port ? i_req1_last : i_req0_last;

    // A done arriving on the expiry cycle wins over the timeout.
    assign w_tmo_next   = f_tmo_inc(r_tmo_cnt);
    assign w_tmo_expire = (w_tmo_next == TMO_LAST);
    assign w_fin        = (r_state == S_WAIT) && (i_m_tx_done || w_tmo_expire);
    assign w_fin_err    = !i_m_tx_done;
    assign w_fin_byte   = i_m_tx_done ? i_m_rx_byte : 8'hFF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= 1'b0;
            r_owner      <= 1'b0;
            r_last       <= 1'b0;
            r_busy       <= 1'b0;
            r_tx_start   <= 1'b0;
            r_tx_byte    <= 8'h00;
            r_tmo_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp0_byte  <= 8'h00;
            r_rsp0_err   <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp1_byte  <= 8'h00;
            r_rsp1_err   <= 1'b0;
        end else begin
            r_tx_start   <= 1'b0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;

            if (w_fin) begin
                if (r_owner) begin
                    r_rsp1_valid <= 1'b1;
                    r_rsp1_byte  <= w_fin_byte;
                    r_rsp1_err   <= w_fin_err;
                end else begin
                    r_rsp0_valid <= 1'b1;
                    r_rsp0_byte  <= w_fin_byte;
                    r_rsp0_err   <= w_fin_err;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_acc) begin
                        r_tx_byte  <= w_acc_byte;
                        r_last     <= w_acc_last;
                        r_owner    <= w_acc_port;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tmo_cnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_m_tx_done && !r_last) begin
                        r_hold_cnt <= '0;
                        r_state    <= S_HOLD;
                    end else if (w_fin) begin
                        // Timeout drops the lock even in the middle of a burst.
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= ~r_owner;
                    end else begin
                        r_tmo_cnt <= w_tmo_next;
                    end
                end
                S_HOLD: begin
                    if (w_acc) begin
                        r_tx_byte  <= w_acc_byte;
                        r_last     <= w_acc_last;
                        r_owner    <= w_acc_port;
                        r_tx_start <= 1'b1;
                        r_state    <= S_START;
                    end else if (r_hold_cnt == HOLD_LAST) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_rr_ptr <= ~r_owner;
                    end else begin
                        r_hold_cnt <= f_hold_inc(r_hold_cnt);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_req0_ready = w_rdy0;
    assign o_req1_ready = w_rdy1;
    assign o_rsp0_valid = r_rsp0_valid;
    assign o_rsp0_byte  = r_rsp0_byte;
    assign o_rsp0_err   = r_rsp0_err;
    assign o_rsp1_valid = r_rsp1_valid;
    assign o_rsp1_byte  = r_rsp1_byte;
    assign o_rsp1_err   = r_rsp1_err;
    assign o_m_tx_byte  = r_tx_byte;
    assign o_m_tx_start = r_tx_start;
    assign o_busy       = r_busy;
    assign o_owner      = r_owner;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed bench for spi_xfer_arbiter with a simple delayed-response SPI master model
// and event logs of accepts, starts, dones and responses.
module tb_spi_xfer_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_req0_valid = 1'b0;
    logic [7:0] i_req0_byte = 8'h00;
    logic       i_req0_last = 1'b0;
    logic       o_req0_ready;
    logic       i_req1_valid = 1'b0;
    logic [7:0] i_req1_byte = 8'h00;
    logic       i_req1_last = 1'b0;
    logic       o_req1_ready;
    logic       o_rsp0_valid;
    logic [7:0] o_rsp0_byte;
    logic       o_rsp0_err;
    logic       o_rsp1_valid;
    logic [7:0] o_rsp1_byte;
    logic       o_rsp1_err;
    logic [7:0] o_m_tx_byte;
    logic       o_m_tx_start;
    logic       m_done = 1'b0;
    logic [7:0] m_rx = 8'h00;
    logic       o_busy;
    logic       o_owner;

    spi_xfer_arbiter #(.TIMEOUT_CYCLES(512), .HOLD_MAX(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_req0_valid (i_req0_valid),
        .i_req0_byte  (i_req0_byte),
        .i_req0_last  (i_req0_last),
        .o_req0_ready (o_req0_ready),
        .i_req1_valid (i_req1_valid),
        .i_req1_byte  (i_req1_byte),
        .i_req1_last  (i_req1_last),
        .o_req1_ready (o_req1_ready),
        .o_rsp0_valid (o_rsp0_valid),
        .o_rsp0_byte  (o_rsp0_byte),
        .o_rsp0_err   (o_rsp0_err),
        .o_rsp1_valid (o_rsp1_valid),
        .o_rsp1_byte  (o_rsp1_byte),
        .o_rsp1_err   (o_rsp1_err),
        .o_m_tx_byte  (o_m_tx_byte),
        .o_m_tx_start (o_m_tx_start),
        .i_m_tx_done  (m_done),
        .i_m_rx_byte  (m_rx),
        .o_busy       (o_busy),
        .o_owner      (o_owner)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // Master model: responds m_delay cycles after a start with tx_byte ^ rx_key,
    // except it never answers stall_byte while stall_en is set.
    int         m_delay = 90;
    logic [7:0] rx_key = 8'h99;
    logic       stall_en = 1'b0;
    logic [7:0] stall_byte = 8'h77;
    int         mcnt = 0;
    logic [7:0] m_cap = 8'h00;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_done = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    m_done = 1'b1;
                    m_rx   = m_cap ^ rx_key;
                end
            end
            if (o_m_tx_start && !(stall_en && o_m_tx_byte == stall_byte)) begin
                mcnt  = m_delay;
                m_cap = o_m_tx_byte;
            end
        end
    end

    int acc_port_q[$];
    int acc_cyc_q[$];
    int st_cyc_q[$];
    int st_byte_q[$];
    int dn_cyc_q[$];
    int rsp_port_q[$];
    int rsp_cyc_q[$];
    int rsp_byte_q[$];
    int rsp_err_q[$];

    always @(negedge clk) begin
        if (i_req0_valid && o_req0_ready) begin
            acc_port_q.push_back(0);
            acc_cyc_q.push_back(cyc);
        end
        if (i_req1_valid && o_req1_ready) begin
            acc_port_q.push_back(1);
            acc_cyc_q.push_back(cyc);
        end
        if (o_m_tx_start) begin
            st_cyc_q.push_back(cyc);
            st_byte_q.push_back(int'(o_m_tx_byte));
        end
        if (m_done) dn_cyc_q.push_back(cyc);
        if (o_rsp0_valid) begin
            rsp_port_q.push_back(0);
            rsp_cyc_q.push_back(cyc);
            rsp_byte_q.push_back(int'(o_rsp0_byte));
            rsp_err_q.push_back(int'(o_rsp0_err));
        end
        if (o_rsp1_valid) begin
            rsp_port_q.push_back(1);
            rsp_cyc_q.push_back(cyc);
            rsp_byte_q.push_back(int'(o_rsp1_byte));
            rsp_err_q.push_back(int'(o_rsp1_err));
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        acc_port_q.delete();
        acc_cyc_q.delete();
        st_cyc_q.delete();
        st_byte_q.delete();
        dn_cyc_q.delete();
        rsp_port_q.delete();
        rsp_cyc_q.delete();
        rsp_byte_q.delete();
        rsp_err_q.delete();
    endtask

    task automatic wait_acc(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && acc_port_q.size() < n; i++) tick();
        chk(tag, 32'(acc_port_q.size() >= n), 32'd1);
    endtask

    task automatic wait_rsp(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && rsp_port_q.size() < n; i++) tick();
        chk(tag, 32'(rsp_port_q.size() >= n), 32'd1);
    endtask

    int t3_port[4] = '{1, 1, 1, 0};
    int t3_byte[4] = '{'h11, 'h22, 'h33, 'h44};
    int t3_next[3] = '{'h11, 'h22, 'h33};

    initial begin
        int k;
        int seen;

        // Reset state, with a valid held high to show ready stays low.
        repeat (3) tick();
        i_req0_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(o_req0_ready), 32'd0);
        chk("rst_flags", 32'({o_busy, o_owner, o_m_tx_start, o_rsp0_valid, o_rsp1_valid,
                               o_rsp0_err, o_rsp1_err, o_req1_ready}), 32'd0);
        chk("rst_bytes", 32'({o_m_tx_byte, o_rsp0_byte, o_rsp1_byte}), 32'd0);
        i_req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // Single byte on port 0.
        clr_logs();
        m_delay = 90;
        i_req0_byte = 8'hA5;
        i_req0_last = 1'b1;
        i_req0_valid = 1'b1;
        wait_acc(1, 10, "t1_acc_timeout");
        i_req0_valid = 1'b0;
        wait_rsp(1, 200, "t1_rsp_timeout");
        tick();
        chk("t1_start_count", 32'(st_cyc_q.size()), 32'd1);
        chk("t1_tx_byte", 32'(st_byte_q[0]), 32'hA5);
        chk("t1_acc_to_start", 32'(st_cyc_q[0] - acc_cyc_q[0]), 32'd1);
        chk("t1_done_to_rsp", 32'(rsp_cyc_q[0] - dn_cyc_q[0]), 32'd1);
        chk("t1_start_to_rsp", 32'(rsp_cyc_q[0] - st_cyc_q[0]), 32'd91);
        chk("t1_rsp_port", 32'(rsp_port_q[0]), 32'd0);
        chk("t1_rsp_byte", 32'(rsp_byte_q[0]), 32'h3C);
        chk("t1_rsp_err", 32'(rsp_err_q[0]), 32'd0);
        chk("t1_idle", 32'(o_busy), 32'd0);
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        #1;
        chk("t1_rr_ptr_ready", 32'({o_req0_ready, o_req1_ready}), 32'b01);
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        repeat (2) tick();
        chk("t1_dropped_valid_no_acc", 32'(acc_port_q.size()), 32'd1);

        // Contention right after reset.
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        clr_logs();
        m_delay = 20;
        i_req0_byte = 8'h01;
        i_req0_last = 1'b1;
        i_req1_byte = 8'h02;
        i_req1_last = 1'b1;
        i_req0_valid = 1'b1;
        i_req1_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (acc_port_q.size() >= 2) i_req1_valid = 1'b0;
            if (acc_port_q.size() >= 3) begin
                i_req0_valid = 1'b0;
                break;
            end
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        wait_rsp(3, 200, "t2_rsp_timeout");
        chk("t2_grant0", 32'(acc_port_q[0]), 32'd0);
        chk("t2_grant1", 32'(acc_port_q[1]), 32'd1);
        chk("t2_grant2", 32'(acc_port_q[2]), 32'd0);
        chk("t2_second_byte", 32'(st_byte_q[1]), 32'h02);
        chk("t2_rsp1_byte", 32'(rsp_byte_q[1]), 32'h9B);

        // Port 1 burst 11,22,33 while port 0 waits.
        tick();
        clr_logs();
        k = 0;
        seen = 0;
        i_req1_byte = 8'h11;
        i_req1_last = 1'b0;
        i_req1_valid = 1'b1;
        i_req0_byte = 8'h44;
        i_req0_last = 1'b1;
        i_req0_valid = 1'b1;
        for (int i = 0; i < 600 && rsp_port_q.size() < 4; i++) begin
            tick();
            while (seen < acc_port_q.size()) begin
                if (acc_port_q[seen] == 1) begin
                    k = k + 1;
                    if (k < 3) begin
                        i_req1_byte = 8'(t3_next[k]);
                        i_req1_last = (k == 2);
                    end else begin
                        i_req1_valid = 1'b0;
                    end
                end else begin
                    i_req0_valid = 1'b0;
                end
                seen = seen + 1;
            end
        end
        i_req0_valid = 1'b0;
        i_req1_valid = 1'b0;
        chk("t3_done", 32'(rsp_port_q.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("t3_acc_port%0d", j), 32'(acc_port_q[j]), 32'(t3_port[j]));
            chk($sformatf("t3_tx_byte%0d", j), 32'(st_byte_q[j]), 32'(t3_byte[j]));
        end
        chk("t3_spacing1", 32'(st_cyc_q[1] - dn_cyc_q[0]), 32'd2);
        chk("t3_spacing2", 32'(st_cyc_q[2] - dn_cyc_q[1]), 32'd2);
        chk("t3_hold_acc_with_rsp", 32'(acc_cyc_q[1] - rsp_cyc_q[0]), 32'd0);
        chk("t3_last_rsp_port", 32'(rsp_port_q[2]), 32'd1);
        chk("t3_last_rsp_byte", 32'(rsp_byte_q[2]), 32'hAA);
        chk("t3_port0_after_release", 32'(acc_cyc_q[3] - rsp_cyc_q[2]), 32'd0);

        // Master never answers port 1's byte; port 0 waits behind it.
        tick();
        clr_logs();
        stall_en = 1'b1;
        i_req1_byte = 8'h77;
        i_req1_last = 1'b1;
        i_req1_valid = 1'b1;
        wait_acc(1, 10, "t4_acc1_timeout");
        i_req1_valid = 1'b0;
        i_req0_byte = 8'h65;
        i_req0_last = 1'b1;
        i_req0_valid = 1'b1;
        wait_acc(2, 600, "t4_acc0_timeout");
        i_req0_valid = 1'b0;
        wait_rsp(2, 100, "t4_rsp_timeout");
        stall_en = 1'b0;
        chk("t4_tmo_port", 32'(rsp_port_q[0]), 32'd1);
        chk("t4_tmo_err", 32'(rsp_err_q[0]), 32'd1);
        chk("t4_tmo_byte", 32'(rsp_byte_q[0]), 32'hFF);
        chk("t4_tmo_latency", 32'(rsp_cyc_q[0] - st_cyc_q[0]), 32'd512);
        chk("t4_next_grant", 32'(acc_port_q[1]), 32'd0);
        chk("t4_next_grant_cyc", 32'(acc_cyc_q[1] - rsp_cyc_q[0]), 32'd0);
        chk("t4_after_rsp", 32'({rsp_port_q[1][0], rsp_err_q[1][0], rsp_byte_q[1][7:0]}),
            32'({1'b0, 1'b0, 8'hFC}));

        // Done arriving on the expiry cycle counts as a normal completion.
        tick();
        clr_logs();
        m_delay = 511;
        i_req1_byte = 8'h5C;
        i_req1_last = 1'b1;
        i_req1_valid = 1'b1;
        wait_acc(1, 10, "t4b_acc_timeout");
        i_req1_valid = 1'b0;
        wait_rsp(1, 700, "t4b_rsp_timeout");
        chk("t4b_err", 32'(rsp_err_q[0]), 32'd0);
        chk("t4b_byte", 32'(rsp_byte_q[0]), 32'hC5);
        chk("t4b_latency", 32'(rsp_cyc_q[0] - st_cyc_q[0]), 32'd512);

        // Port 0 abandons its burst after one byte.
        tick();
        clr_logs();
        m_delay = 20;
        i_req0_byte = 8'h55;
        i_req0_last = 1'b0;
        i_req0_valid = 1'b1;
        wait_acc(1, 10, "t5_acc0_timeout");
        i_req0_valid = 1'b0;
        i_req1_byte = 8'h2B;
        i_req1_last = 1'b1;
        i_req1_valid = 1'b1;
        wait_rsp(1, 100, "t5_rsp0_timeout");
        repeat (10) tick();
        chk("t5_hold_lock", 32'({o_busy, o_req0_ready, o_req1_ready}), 32'b110);
        wait_acc(2, 200, "t5_acc1_timeout");
        i_req1_valid = 1'b0;
        wait_rsp(2, 100, "t5_rsp1_timeout");
        chk("t5_rsp0_byte", 32'(rsp_byte_q[0]), 32'hCC);
        chk("t5_release_delay", 32'(acc_cyc_q[1] - rsp_cyc_q[0]), 32'd64);
        chk("t5_no_silent_rsp", 32'(rsp_port_q[1]), 32'd1);
        chk("t5_starts", 32'(st_cyc_q.size()), 32'd2);

        // Reset in the middle of a transfer; the late done must be ignored.
        tick();
        clr_logs();
        m_delay = 100;
        i_req1_byte = 8'h9A;
        i_req1_last = 1'b1;
        i_req1_valid = 1'b1;
        wait_acc(1, 10, "t6_acc_timeout");
        i_req1_valid = 1'b0;
        repeat (10) tick();
        chk("t6_pre_reset", 32'({o_busy, o_owner}), 32'b11);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_flags", 32'({o_busy, o_owner, o_m_tx_start, o_rsp0_valid, o_rsp1_valid,
                                 o_rsp0_err, o_rsp1_err, o_req0_ready, o_req1_ready}), 32'd0);
        chk("t6_rst_bytes", 32'({o_m_tx_byte, o_rsp0_byte, o_rsp1_byte}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        for (int i = 0; i < 200 && dn_cyc_q.size() < 1; i++) tick();
        repeat (2) tick();
        chk("t6_late_done_seen", 32'(dn_cyc_q.size()), 32'd1);
        chk("t6_late_done_ignored", 32'({o_busy, 8'(rsp_port_q.size())}), 32'd0);
        m_delay = 30;
        i_req0_byte = 8'h12;
        i_req0_last = 1'b1;
        i_req0_valid = 1'b1;
        wait_acc(2, 10, "t6_acc0_timeout");
        i_req0_valid = 1'b0;
        wait_rsp(1, 100, "t6_rsp_timeout");
        chk("t6_fresh_rsp", 32'({rsp_port_q[0][0], rsp_err_q[0][0], rsp_byte_q[0][7:0]}),
            32'({1'b0, 1'b0, 8'h8B}));
        chk("t6_fresh_latency", 32'(rsp_cyc_q[0] - st_cyc_q[1]), 32'd31);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
